// File: rtl/led_ctrl_pkg.sv
// rtl/led_ctrl_pkg.sv - shared mode enum and default sizing for the LED pattern controller
package led_ctrl_pkg;

    // Active display pattern; encoding matches the mode_sel input
    typedef enum logic [1:0] {
        BOUNCE = 2'd0,
        FILL   = 2'd1,
        BLINK  = 2'd2,
        OFF    = 2'd3
    } led_mode_e;

    localparam int DEF_N_LEDS   = 10;
    localparam int DEF_TICK_DIV = 2097152;

endpackage

// File: rtl/led_tick_gen.sv
// rtl/led_tick_gen.sv - step prescaler counting 0..TICK_DIV-1 with clear and hold
module led_tick_gen
    import led_ctrl_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic hold,
    output logic step
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Clear beats hold; step fires only on the edge that leaves LAST
    always_comb begin
        cnt_d = cnt_q;
        step  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (!hold) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                step  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Prescaler count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_pattern_ctrl.sv
// rtl/led_pattern_ctrl.sv - LED pattern sequencer with mode handshake; optional PWM dimming via LED_PATTERN_CTRL_PWM_EN
module led_pattern_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int N_LEDS   = DEF_N_LEDS,
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode_req,
    input  logic [1:0]        mode_sel,
    input  logic              pause,
`ifdef LED_PATTERN_CTRL_PWM_EN
    input  logic [3:0]        duty,
`endif
    output logic              mode_ack,
    output logic [1:0]        mode,
    output logic              tick,
    output logic [N_LEDS-1:0] led
);

    localparam int PW = (N_LEDS > 2) ? $clog2(N_LEDS) : 1;
    localparam logic [PW-1:0]     LAST_POS = PW'(N_LEDS - 1);
    localparam logic [N_LEDS-1:0] ONE      = N_LEDS'(1);

    logic step;

    led_mode_e         mode_q, mode_d;
    logic [N_LEDS-1:0] pat_q, pat_d;
    logic [PW-1:0]     pos_q, pos_d, pos_nx;
    logic              dir_up_q, dir_up_d;
    logic              tick_q, tick_d;
    logic              ack_q, ack_d;

    // A request clears the prescaler so the new pattern gets a full step period
    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (mode_req),
        .hold (pause),
        .step (step)
    );

    // Next-state: a request wins over a coincident step; otherwise advance on step
    always_comb begin
        mode_d   = mode_q;
        pat_d    = pat_q;
        pos_d    = pos_q;
        dir_up_d = dir_up_q;
        tick_d   = 1'b0;
        ack_d    = 1'b0;
        pos_nx   = dir_up_q ? (pos_q + 1'b1) : (pos_q - 1'b1);
        if (mode_req) begin
            mode_d   = led_mode_e'(mode_sel);
            ack_d    = 1'b1;
            pos_d    = '0;
            dir_up_d = 1'b1;
            case (led_mode_e'(mode_sel))
                BOUNCE:  pat_d = ONE;
                BLINK:   pat_d = '1;
                default: pat_d = '0;
            endcase
        end else if (step) begin
            tick_d = 1'b1;
            case (mode_q)
                BOUNCE: begin
                    // Reverse on the very step that lands on an end
                    pos_d = pos_nx;
                    if (pos_nx == LAST_POS) begin
                        dir_up_d = 1'b0;
                    end else if (pos_nx == '0) begin
                        dir_up_d = 1'b1;
                    end
                    pat_d = ONE << pos_nx;
                end
                FILL:    pat_d = (&pat_q) ? '0 : {pat_q[N_LEDS-2:0], 1'b1};
                BLINK:   pat_d = ~pat_q;
                default: pat_d = '0;
            endcase
        end
    end

    // Pattern, mode and handshake registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q   <= BOUNCE;
            pat_q    <= ONE;
            pos_q    <= '0;
            dir_up_q <= 1'b1;
            tick_q   <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            pat_q    <= pat_d;
            pos_q    <= pos_d;
            dir_up_q <= dir_up_d;
            tick_q   <= tick_d;
            ack_q    <= ack_d;
        end
    end

`ifdef LED_PATTERN_CTRL_PWM_EN
    logic [3:0]        pwm_q;
    logic [N_LEDS-1:0] led_q;

    // Free-running PWM phase; led is gated by the phase at the edge it is loaded
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_q <= '0;
            led_q <= ONE;
        end else begin
            pwm_q <= pwm_q + 1'b1;
            led_q <= pat_d & {N_LEDS{pwm_q < duty}};
        end
    end

    assign led = led_q;
`else
    assign led = pat_q;
`endif

    assign mode     = mode_q;
    assign tick     = tick_q;
    assign mode_ack = ack_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb/tb_led_pattern_ctrl.sv - scoreboard bench for led_pattern_ctrl (N_LEDS=10, TICK_DIV=4)
module tb_led_pattern_ctrl;

    localparam int N  = 10;
    localparam int TD = 4;

    typedef struct packed {
        logic [N-1:0] led;
        logic         tick;
        logic [1:0]   mode;
        logic         ack;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         mode_req = 1'b0;
    logic [1:0]   mode_sel = 2'd0;
    logic         pause = 1'b0;
    logic [3:0]   duty = 4'd15;
    logic         mode_ack;
    logic [1:0]   mode;
    logic         tick;
    logic [N-1:0] led;

    int checks   = 0;
    int failures = 0;

    exp_t exp_q[$];

    // Reference model state
    int         m_presc;
    int         m_k;
    int         m_fill;
    logic       m_blink;
    logic [1:0] m_mode;
    logic       m_ack;
    logic       m_tick;
    logic [3:0] m_pwm;

    led_pattern_ctrl #(
        .N_LEDS   (N),
        .TICK_DIV (TD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mode_req (mode_req),
        .mode_sel (mode_sel),
        .pause    (pause),
`ifdef LED_PATTERN_CTRL_PWM_EN
        .duty     (duty),
`endif
        .mode_ack (mode_ack),
        .mode     (mode),
        .tick     (tick),
        .led      (led)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_presc = 0;
        m_k     = 0;
        m_fill  = 0;
        m_blink = 1'b1;
        m_mode  = 2'd0;
        m_ack   = 1'b0;
        m_tick  = 1'b0;
        m_pwm   = 4'd0;
    endtask

    task automatic model_edge(input logic req, input logic [1:0] sel, input logic pse);
        exp_t   e;
        int     pos;
        logic   gate;
        logic [31:0] p;
        if (req) begin
            m_mode  = sel;
            m_presc = 0;
            m_k     = 0;
            m_fill  = 0;
            m_blink = 1'b1;
            m_ack   = 1'b1;
            m_tick  = 1'b0;
        end else begin
            m_ack  = 1'b0;
            m_tick = 1'b0;
            if (!pse) begin
                if (m_presc == TD - 1) begin
                    m_presc = 0;
                    m_tick  = 1'b1;
                    m_k     = (m_k + 1) % (2 * N - 2);
                    m_fill  = (m_fill + 1) % (N + 1);
                    m_blink = ~m_blink;
                end else begin
                    m_presc++;
                end
            end
        end
        pos = (m_k < N) ? m_k : (2 * N - 2 - m_k);
        case (m_mode)
            2'd0:    p = 32'd1 << pos;
            2'd1:    p = (32'd1 << m_fill) - 32'd1;
            2'd2:    p = m_blink ? ((32'd1 << N) - 32'd1) : 32'd0;
            default: p = 32'd0;
        endcase
`ifdef LED_PATTERN_CTRL_PWM_EN
        gate  = (m_pwm < duty);
        m_pwm = m_pwm + 4'd1;
`else
        gate = 1'b1;
`endif
        e.led  = gate ? p[N-1:0] : '0;
        e.tick = m_tick;
        e.mode = m_mode;
        e.ack  = m_ack;
        exp_q.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        e = exp_q.pop_front();
        chk("led",  32'(led),      32'(e.led));
        chk("tick", 32'(tick),     32'(e.tick));
        chk("mode", 32'(mode),     32'(e.mode));
        chk("ack",  32'(mode_ack), 32'(e.ack));
    endtask

    task automatic cycle(input logic req, input logic [1:0] sel, input logic pse);
        mode_req = req;
        mode_sel = sel;
        pause    = pse;
        model_edge(req, sel, pse);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, 1'b0);
    endtask

    initial begin
        int guard;
        // Reset held across several edges
        repeat (3) @(posedge clk);
        #1;
        chk("rst_led",  32'(led),      32'd1);
        chk("rst_mode", 32'(mode),     32'd0);
        chk("rst_tick", 32'(tick),     32'd0);
        chk("rst_ack",  32'(mode_ack), 32'd0);
        #2;
        rst = 1'b0;
        model_reset();

        // Free-running BOUNCE
        run(80);

        // Switch to FILL and sweep past full
        cycle(1'b1, 2'd1, 1'b0);
        run(48);

        // Request landing exactly on a step edge
        guard = 0;
        while (m_presc != TD - 1 && guard < 8) begin
            cycle(1'b0, 2'd0, 1'b0);
            guard++;
        end
        chk("align_step", 32'(m_presc), 32'(TD - 1));
        cycle(1'b1, 2'd2, 1'b0);
        run(10);

        // Pause mid-BLINK, then resume
        for (int i = 0; i < 20; i++) cycle(1'b0, 2'd0, 1'b1);
        run(12);

        // Same-mode restart, then a request while paused
        cycle(1'b1, 2'd2, 1'b0);
        run(6);
        cycle(1'b0, 2'd0, 1'b1);
        cycle(1'b1, 2'd3, 1'b1);
        cycle(1'b0, 2'd0, 1'b1);
        run(10);

        // Request held high re-acks every cycle
        for (int i = 0; i < 3; i++) cycle(1'b1, 2'd0, 1'b0);
        run(9);

`ifdef LED_PATTERN_CTRL_PWM_EN
        duty = 4'd4;
        run(32);
        duty = 4'd0;
        run(8);
        duty = 4'd15;
`endif

        // FILL, then an asynchronous reset pulse between edges
        cycle(1'b1, 2'd1, 1'b0);
        run(10);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_led",  32'(led),      32'd1);
        chk("arst_mode", 32'(mode),     32'd0);
        chk("arst_tick", 32'(tick),     32'd0);
        chk("arst_ack",  32'(mode_ack), 32'd0);
        #2;
        rst = 1'b0;
        model_reset();
        run(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
